// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard unit: forwarding selects,
// data-memory wait FSM states and the default wait timeout.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    ERROR = 2'b10
  } mem_state_e;

  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one Execute operand; purely combinational, zero latency.
// Memory-stage producer has priority over Writeback; x0 is never forwarded.
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
  end

  assign fwd = sel;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: stall/flush/forward decisions are combinational (no latency);
// a data-memory wait FSM flags a sticky timeout and saturating counters track stalls and flushes.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             DmemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int WCNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TIMEOUT_C = WCNT_W'(TIMEOUT);

  logic lw_stall;
  logic mem_stall;

  mem_state_e        state;
  logic [WCNT_W-1:0] wait_cnt;

  assign lw_stall  = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_stall = MemReqM && !DmemReadyM;

  assign StallF = lw_stall || mem_stall;
  assign StallD = lw_stall || mem_stall;
  assign StallE = mem_stall;
  assign StallM = mem_stall;

  // A frozen Memory stage must not re-commit into Writeback, and redirects
  // wait until the pipeline moves again so the branch is not lost.
  assign FlushW = mem_stall;
  assign FlushD = PCSrcE && !mem_stall;
  assign FlushE = (lw_stall || PCSrcE) && !mem_stall;

  hazard_fwd_sel u_fwd_a (
    .rs          (Rs1E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .fwd         (ForwardAE)
  );

  hazard_fwd_sel u_fwd_b (
    .rs          (Rs2E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .fwd         (ForwardBE)
  );

  // ERROR is absorbing; only reset leaves it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      MemTimeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_stall) begin
            state    <= WAIT;
            wait_cnt <= WCNT_W'(1);
          end
        end
        WAIT: begin
          if (!mem_stall) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else if (wait_cnt == TIMEOUT_C) begin
            state      <= ERROR;
            MemTimeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        ERROR: begin
          MemTimeout <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          wait_cnt   <= '0;
          MemTimeout <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (StallF && (StallCycles != {CNT_W{1'b1}})) begin
        StallCycles <= StallCycles + CNT_W'(1);
      end
      if ((FlushD || FlushE) && (FlushCount != {CNT_W{1'b1}})) begin
        FlushCount <= FlushCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum consecutive data-memory wait cycles before a timeout is flagged.
REQ-002 Parameter CNT_W, default 32: width of the performance counters.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 Rs1D, Rs2D  in  5 each  source registers of the instruction in Decode.
REQ-006 Rs1E, Rs2E, RdE  in  5 each  source and destination registers in Execute.
REQ-007 ResultSrcE0  in  1  Execute instruction is a load.
REQ-008 PCSrcE  in  1  taken branch or jump resolved in Execute.
REQ-009 RdM, RdW  in  5 each; RegWriteM, RegWriteW  in  1 each  writeback info for Memory and Writeback.
REQ-010 MemReqM  in  1; DmemReadyM  in  1  data-memory request in Memory, and its completion acknowledge.
REQ-011 StallF, StallD, StallE, StallM  out  1 each  low-active enables for the PC, IF/ID, ID/EX and EX/MEM registers.
REQ-012 FlushD, FlushE, FlushW  out  1 each  synchronous clears for IF/ID, ID/EX and MEM/WB.
REQ-013 ForwardAE, ForwardBE  out  2 each  forwarding select: 00 = register file, 01 = Writeback result, 10 = Memory ALU result.
REQ-014 MemTimeout  out  1  sticky timeout flag.
REQ-015 StallCycles, FlushCount  out  CNT_W each  performance counters.

Function
REQ-016 lwStall SHALL be ResultSrcE0 and RdE != 0 and (RdE == Rs1D or RdE == Rs2D).
REQ-017 memStall SHALL be MemReqM and not DmemReadyM; it is combinational and has no latency.
REQ-018 StallF and StallD SHALL equal lwStall or memStall.
REQ-019 StallE and StallM SHALL equal memStall.
REQ-020 FlushW SHALL equal memStall, so a bubble enters Writeback while Memory is frozen.
REQ-021 FlushD SHALL equal PCSrcE and not memStall.
REQ-022 FlushE SHALL equal (lwStall or PCSrcE) and not memStall. A held branch therefore flushes in the cycle memStall drops.
REQ-023 ForwardAE SHALL be:
- 10 if RegWriteM, RdM != 0 and RdM == Rs1E;
- else 01 if RegWriteW, RdW != 0 and RdW == Rs1E;
- else 00.
The Memory stage wins on a double match. ForwardBE SHALL be identical, using Rs2E.
REQ-024 The FSM SHALL have states IDLE, WAIT and ERROR, with a wait counter sized for TIMEOUT.
REQ-025 IDLE -> WAIT when memStall; the wait counter loads 1.
REQ-026 WAIT -> IDLE when DmemReadyM or not MemReqM; the counter clears.
REQ-027 WAIT holds while memStall and the counter is below TIMEOUT; the counter increments each cycle.
REQ-028 WAIT -> ERROR when memStall and the counter equals TIMEOUT.
REQ-029 ERROR SHALL be absorbing until reset; MemTimeout = 1 only in ERROR. Stall and flush outputs keep following REQ-016..022 in ERROR.
REQ-030 StallCycles SHALL increment each cycle StallF = 1, and saturate at all-ones.
REQ-031 FlushCount SHALL increment each cycle FlushD or FlushE = 1, and saturate at all-ones.

Reset
REQ-032 While rst = 0:
- FSM = IDLE; wait counter, MemTimeout, StallCycles and FlushCount = 0;
- combinational outputs still follow their inputs.
REQ-033 Reset asserted in WAIT or ERROR SHALL return the FSM to IDLE on the next cycle with rst = 1, with no residual timeout.

Structure
REQ-034 Package hazard_pkg SHALL hold:
- the fwd_sel_e enum (FWD_RF = 00, FWD_WB = 01, FWD_MEM = 10);
- the mem_state_e enum (IDLE, WAIT, ERROR);
- the default TIMEOUT constant.
REQ-035 A single sub-module, hazard_fwd_sel, SHALL compute one forwarding select and be instantiated twice (A and B operands).

Verification
REQ-036 Load-use: ResultSrcE0 = 1, RdE = 5, Rs2D = 5 -> StallF = StallD = FlushE = 1; StallE = 0; ForwardAE = ForwardBE = 00.
REQ-037 x0 guard: RdE = 0, Rs1D = 0, ResultSrcE0 = 1 -> no stall. RegWriteM = 1, RdM = 0, Rs1E = 0 -> ForwardAE = 00.
REQ-038 Double match: RdM = RdW = 7, both RegWrite = 1, Rs1E = Rs2E = 7 -> ForwardAE = ForwardBE = 10. Deassert RegWriteM -> both 01.
REQ-039 Branch under memory wait: PCSrcE = 1, MemReqM = 1, DmemReadyM = 0 for 3 cycles, then 1:
- during the wait, FlushD = FlushE = 0 and all Stall* = 1;
- in the ready cycle, FlushD = FlushE = 1;
- StallCycles increases by 3 and FlushCount by 1.
REQ-040 Timeout with TIMEOUT = 4: MemReqM = 1, DmemReadyM = 0 held -> MemTimeout rises on the 5th clock edge and stays 1 after DmemReadyM = 1. Pulse rst low mid-state -> MemTimeout = 0 immediately, FSM = IDLE.
REQ-041 Counter saturation with CNT_W = 4: hold lwStall for 20 cycles -> StallCycles = 15 and stays 15.
